// File: rtl/instr_decode_ctrl.sv
// instr_decode_ctrl: multicycle fetch/decode/execute controller for a register-file/ALU datapath
module instr_decode_ctrl #(
  parameter logic [1:0] P_BZ_CTRL = 2'b00,
  parameter int P_PC_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [15:0]       instr,
  input  logic              Zero,
  output logic [P_PC_W-1:0] imem_addr,
  output logic [3:0]        RA1,
  output logic [3:0]        RA2,
  output logic [3:0]        WA,
  output logic [7:0]        immediate,
  output logic [1:0]        ALUControl,
  output logic              ALUSrc,
  output logic              write_enable,
  output logic              halted,
  output logic [P_PC_W-1:0] pc
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, HALT} state_t;
  state_t state;
  logic [15:0] ir;
  logic [3:0] op;
  logic r_type, i_type, bz, jmp, hlt;
  logic [P_PC_W-1:0] target, pc_inc;
  assign op = ir[15:12];
  assign r_type = op[3:2] == 2'b00;
  assign i_type = op[3:2] == 2'b01;
  assign bz = op == 4'b1000;
  assign jmp = op == 4'b1001;
  assign hlt = op == 4'b1111;
  assign target = P_PC_W'(ir[7:0]);
  assign pc_inc = pc + 1'b1;
  assign imem_addr = pc;
  // datapath fields decoded from IR in every state; JMP/HALT/NOP leave them all at 0
  always_comb begin
    ALUControl = (r_type | i_type) ? op[1:0] : bz ? P_BZ_CTRL : 2'b00;
    ALUSrc = i_type | bz;
    WA = (r_type | i_type) ? ir[11:8] : 4'd0;
    RA1 = r_type ? ir[7:4] : (i_type | bz) ? ir[11:8] : 4'd0;
    RA2 = r_type ? ir[3:0] : 4'd0;
    immediate = i_type ? ir[7:0] : 8'd0;
  end
  // controller FSM: write strobe raised on entry to EXECUTE, halted raised on entry to HALT
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      ir <= 16'hA000;
      write_enable <= 1'b0;
      halted <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      case (state)
        IDLE: state <= run ? FETCH : IDLE;
        FETCH: state <= DECODE;
        DECODE: begin
          ir <= instr;
          write_enable <= ~instr[15];
          state <= EXECUTE;
        end
        EXECUTE: begin
          pc <= hlt ? pc : jmp ? target : (bz & Zero) ? target : pc_inc;
          halted <= hlt;
          state <= hlt ? HALT : run ? FETCH : IDLE;
        end
        default: begin
          halted <= 1'b1;
          state <= HALT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_decode_ctrl.sv
// tb_instr_decode_ctrl: directed self-checking bench with a 1-cycle-latency ROM model
module tb_instr_decode_ctrl;
  logic clk = 1'b0;
  logic reset, run, zero;
  logic [15:0] instr;
  logic [7:0] imem_addr, immediate, pc;
  logic [3:0] ra1, ra2, wa;
  logic [1:0] alu_control;
  logic alu_src, write_enable, halted;
  logic [15:0] rom [256];
  int errors = 0;
  int checks = 0;
  instr_decode_ctrl #(.P_BZ_CTRL(2'b00), .P_PC_W(8)) dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .Zero(zero),
    .imem_addr(imem_addr), .RA1(ra1), .RA2(ra2), .WA(wa), .immediate(immediate),
    .ALUControl(alu_control), .ALUSrc(alu_src), .write_enable(write_enable),
    .halted(halted), .pc(pc)
  );
  always #5 clk = ~clk;
  always @(posedge clk) instr <= rom[imem_addr];
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_we"}, 16'(write_enable), 16'd0);
    chk({tag, "_wa"}, 16'(wa), 16'd0);
    chk({tag, "_ra1"}, 16'(ra1), 16'd0);
    chk({tag, "_ra2"}, 16'(ra2), 16'd0);
    chk({tag, "_imm"}, 16'(immediate), 16'd0);
    chk({tag, "_aluc"}, 16'(alu_control), 16'd0);
    chk({tag, "_alusrc"}, 16'(alu_src), 16'd0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hA000;
    rom[8'h00] = 16'h4105;
    rom[8'h01] = 16'h3312;
    rom[8'h02] = 16'h8240;
    rom[8'h40] = 16'h8240;
    rom[8'h41] = 16'h90FF;
    rom[8'h43] = 16'hF000;
    reset = 1'b1;
    run = 1'b0;
    zero = 1'b0;
    @(negedge clk);
    tick(1);
    reset = 1'b0;
    chk_quiet("rst");
    chk("rst_addr", 16'(imem_addr), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);
    run = 1'b1;
    tick(3);
    chk("addi_wa", 16'(wa), 16'd1);
    chk("addi_ra1", 16'(ra1), 16'd1);
    chk("addi_imm", 16'(immediate), 16'd5);
    chk("addi_alusrc", 16'(alu_src), 16'd1);
    chk("addi_aluc", 16'(alu_control), 16'd0);
    chk("addi_we", 16'(write_enable), 16'd1);
    tick(1);
    chk("addi_we_drop", 16'(write_enable), 16'd0);
    chk("addi_pc", 16'(imem_addr), 16'd1);
    rom[8'h00] = 16'h9043;
    tick(1);
    run = 1'b0;
    tick(1);
    chk("r_aluc", 16'(alu_control), 16'd3);
    chk("r_wa", 16'(wa), 16'd3);
    chk("r_ra1", 16'(ra1), 16'd1);
    chk("r_ra2", 16'(ra2), 16'd2);
    chk("r_alusrc", 16'(alu_src), 16'd0);
    chk("r_we", 16'(write_enable), 16'd1);
    tick(3);
    chk("pause_pc", 16'(imem_addr), 16'd2);
    chk("pause_we", 16'(write_enable), 16'd0);
    run = 1'b1;
    tick(1);
    chk("resume_pc", 16'(imem_addr), 16'd2);
    tick(2);
    zero = 1'b1;
    chk("bz1_we", 16'(write_enable), 16'd0);
    chk("bz1_ra1", 16'(ra1), 16'd2);
    chk("bz1_alusrc", 16'(alu_src), 16'd1);
    chk("bz1_imm", 16'(immediate), 16'd0);
    chk("bz1_aluc", 16'(alu_control), 16'd0);
    tick(1);
    zero = 1'b0;
    chk("bz_taken", 16'(imem_addr), 16'h40);
    tick(2);
    chk("bz0_we", 16'(write_enable), 16'd0);
    tick(1);
    chk("bz_not_taken", 16'(imem_addr), 16'h41);
    tick(2);
    chk_quiet("jmp");
    tick(1);
    chk("jmp_pc", 16'(imem_addr), 16'hFF);
    tick(3);
    chk("wrap_pc", 16'(imem_addr), 16'h00);
    tick(3);
    chk("jmp2_pc", 16'(imem_addr), 16'h43);
    tick(3);
    chk("halt_halted", 16'(halted), 16'd1);
    chk("halt_addr", 16'(imem_addr), 16'h43);
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      tick(1);
      chk("halt_hold_we", 16'(write_enable), 16'd0);
      chk("halt_hold_addr", 16'(imem_addr), 16'h43);
      chk("halt_hold_halted", 16'(halted), 16'd1);
    end
    run = 1'b1;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    run = 1'b0;
    chk("halt_rst_halted", 16'(halted), 16'd0);
    chk("halt_rst_addr", 16'(imem_addr), 16'd0);
    chk("halt_rst_we", 16'(write_enable), 16'd0);
    rom[8'h00] = 16'h4105;
    run = 1'b1;
    tick(1);
    chk("idle_run_addr", 16'(imem_addr), 16'd0);
    tick(2);
    chk("ex_rst_pre_we", 16'(write_enable), 16'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    run = 1'b0;
    chk_quiet("ex_rst");
    chk("ex_rst_addr", 16'(imem_addr), 16'd0);
    chk("ex_rst_halted", 16'(halted), 16'd0);
    tick(2);
    chk("ex_rst_idle_addr", 16'(imem_addr), 16'd0);
    chk("ex_rst_idle_we", 16'(write_enable), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
